duty_ramp_ctrl: RTL and testbench
=================================

// Module: duty_ramp_ctrl
// PURPOSE
//  Soft-start/slew controller upstream of the PWM generator: drives its duty[7:0] and enable.
//  Accepts target-duty commands over a valid/ready handshake.
//  Slews duty toward the target by STEP once per prescaled tick.
//  Ramps down to zero on disable; forces zero immediately on fault (latched until cleared).
// PARAMETERS
//  DUTY_W    8      duty width; matches the PWM generator duty input
//  TICK_DIV  50000  clk cycles per ramp tick (1 kHz at 50 MHz clk); >=2
//  STEP      1      duty increment per tick; 1..2^DUTY_W-1
// PORTS
//  clk           in   1       system clock, rising edge
//  rst_n         in   1       asynchronous reset, active low
//  enable_req    in   1       level: run the motor/output
//  cmd_valid     in   1       target duty command valid
//  cmd_duty      in   DUTY_W  target duty
//  cmd_ready     out  1       command can be accepted this cycle
//  fault         in   1       external fault, level
//  clear_fault   in   1       single-cycle pulse: clear latched fault
//  duty          out  DUTY_W  duty to PWM generator, registered
//  pwm_en        out  1       enable to PWM generator, registered
//  at_target     out  1       duty==target and state HOLD, registered
//  fault_latched out  1       state==FAULT, registered
// BEHAVIOUR
//  Reset (rst_n=0, async): duty=0, pwm_en=0, at_target=0, fault_latched=0, target=0, tick cnt=0, state IDLE.
//  Handshake: cmd_ready = (state!=FAULT) && !fault (combinational). On valid&&ready, target<=cmd_duty;
//   the new target is used from the next cycle. A tick in the same cycle uses the old target.
//  Tick: prescaler counts 0..TICK_DIV-1, pulses on wrap. Runs only in RAMP/STOP; cleared on entering them.
//   First step occurs TICK_DIV cycles after entry.
//  Step: diff = target-duty in DUTY_W+1 signed. If |diff|<=STEP then duty<=target, else duty<=duty+/-STEP.
//   Never overshoots and never wraps past 0 or 2^DUTY_W-1.
//  States:
//   IDLE : duty=0, pwm_en=0. enable_req && target!=0 -> RAMP.
//   RAMP : pwm_en=1; step on tick. duty reaches target -> HOLD (same cycle as final step).
//   HOLD : pwm_en=1, at_target=1. Accepted cmd with target!=duty -> RAMP. target==0 holds duty 0 with pwm_en=1.
//   STOP : pwm_en=1; steps toward 0 on tick.
//          duty==0 -> IDLE (pwm_en=0 next cycle).
//          enable_req reasserted -> RAMP, continuing from the current duty.
//          Commands are accepted and only update target.
//   FAULT: duty=0, pwm_en=0, fault_latched=1. clear_fault && !fault -> IDLE. clear_fault while fault=1 is ignored.
//  Transition priority:
//   1. fault=1 -> FAULT next cycle from any state; duty/pwm_en go to 0 in that same edge.
//   2. enable_req=0 in RAMP/HOLD -> STOP.
//   3. RAMP/HOLD retarget.
//  Mid-ramp retarget: direction may reverse; stepping continues from the current duty, tick phase is not reset.
//  Latency: fault -> outputs 0 in 1 clk. Target accept -> first duty change within TICK_DIV+1 clk.
// STRUCTURE
//  pwm_pkg: state enum (IDLE, RAMP, HOLD, STOP, FAULT), DUTY_W default, PWM_PERIOD constant.
//  Sub-module tick_prescaler (params DIV): inputs clk, rst_n, run; output tick. Count clears when run=0.
//  FSM, target register and step arithmetic live in duty_ramp_ctrl.
// TESTING (bench: TICK_DIV=4, STEP=16, DUTY_W=8)
//  1. Reset mid-RAMP at duty 0x30 -> duty=0, pwm_en=0, state IDLE immediately.
//     After release, cmd_ready=1.
//  2. Ramp up: enable_req=1, cmd 0x40.
//     -> pwm_en=1; duty 0x10,0x20,0x30,0x40 on ticks 4 clk apart.
//     -> at_target=1 after 0x40.
//  3. Clamp, no overshoot: from HOLD 0x40, cmd 0x45 -> 0x45 on the next tick.
//     Then cmd 0xFF from 0xF0 -> 0xFF (no wrap).
//     Cmd 0x10 mid-ramp up at 0x30 -> 0x20, 0x10, HOLD.
//  4. Disable: enable_req=0 at HOLD 0x40 -> 0x30,0x20,0x10,0x00, then pwm_en=0, IDLE.
//     Re-enable at 0x20 -> RAMP back up from 0x20.
//  5. Fault at duty 0x30 -> next clk duty=0, pwm_en=0, fault_latched=1, cmd_ready=0.
//     clear_fault with fault=1 ignored; fault=0 + clear_fault -> IDLE.
//  6. Simultaneous: cmd_valid+fault same cycle -> not accepted, FAULT.
//     cmd accept on tick cycle -> step uses old target.

Source files
------------

// File: rtl/duty_ramp_ctrl_pkg.sv
// Shared types and constants for the duty ramp controller and the PWM path it feeds.
package duty_ramp_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RAMP,
        ST_HOLD,
        ST_STOP,
        ST_FAULT
    } state_e;

    localparam int DUTY_W_DEF = 8;
    localparam int PWM_PERIOD = 1 << DUTY_W_DEF;

endpackage

// File: rtl/duty_ramp_ctrl_tick_prescaler.sv
// Divides clk down to a single-cycle ramp tick; the count is held at zero while run is low.
module tick_prescaler #(
    parameter int DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic tick
);

    localparam int              CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]   LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!run || r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign tick = run && (r_cnt == LAST);

endmodule

// File: rtl/duty_ramp_ctrl.sv
// Soft-start / slew controller: moves the PWM duty toward a commanded target one STEP per tick,
// ramps to zero on disable and drops to zero at once on a fault.
module duty_ramp_ctrl
    import duty_ramp_ctrl_pkg::*;
#(
    parameter int DUTY_W   = DUTY_W_DEF,
    parameter int TICK_DIV = 50000,
    parameter int STEP     = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable_req,
    input  logic              cmd_valid,
    input  logic [DUTY_W-1:0] cmd_duty,
    output logic              cmd_ready,
    input  logic              fault,
    input  logic              clear_fault,
    output logic [DUTY_W-1:0] duty,
    output logic              pwm_en,
    output logic              at_target,
    output logic              fault_latched,
    output state_e            dbg_state
);

    localparam logic [DUTY_W:0]   STEP_W = (DUTY_W + 1)'(STEP);
    localparam logic [DUTY_W-1:0] STEP_D = DUTY_W'(STEP);

    state_e            r_state;
    logic [DUTY_W-1:0] r_target;
    logic [DUTY_W-1:0] r_duty;
    logic              r_pwm_en;
    logic              r_at_target;
    logic              r_fault_latched;

    logic              w_run;
    logic              w_tick;
    logic              w_accept;
    logic [DUTY_W-1:0] w_step_target;
    logic [DUTY_W-1:0] w_step_zero;

    // One step from cur toward goal; lands exactly on goal when within STEP, so it never overshoots or wraps.
    function automatic logic [DUTY_W-1:0] step_toward(input logic [DUTY_W-1:0] cur,
                                                      input logic [DUTY_W-1:0] goal);
        logic signed [DUTY_W:0] diff;
        logic [DUTY_W:0]        mag;
        diff = $signed({1'b0, goal}) - $signed({1'b0, cur});
        mag  = diff[DUTY_W] ? $unsigned(-diff) : $unsigned(diff);
        if (mag <= STEP_W) begin
            step_toward = goal;
        end else if (diff[DUTY_W]) begin
            step_toward = cur - STEP_D;
        end else begin
            step_toward = cur + STEP_D;
        end
    endfunction

    // Handshake: a command transfers on any cycle with cmd_valid && cmd_ready; cmd_ready depends only
    // on state and the live fault input, never on cmd_valid. The new target is seen from the next cycle.
    assign cmd_ready = (r_state != ST_FAULT) && !fault;
    assign w_accept  = cmd_valid && cmd_ready;

    assign w_run         = (r_state == ST_RAMP) || (r_state == ST_STOP);
    assign w_step_target = step_toward(r_duty, r_target);
    assign w_step_zero   = step_toward(r_duty, '0);

    tick_prescaler #(.DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (w_run),
        .tick  (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_target <= '0;
        end else if (w_accept) begin
            r_target <= cmd_duty;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= ST_IDLE;
            r_duty          <= '0;
            r_pwm_en        <= 1'b0;
            r_at_target     <= 1'b0;
            r_fault_latched <= 1'b0;
        end else if (fault) begin
            r_state         <= ST_FAULT;
            r_duty          <= '0;
            r_pwm_en        <= 1'b0;
            r_at_target     <= 1'b0;
            r_fault_latched <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (enable_req && r_target != '0) begin
                        r_state  <= ST_RAMP;
                        r_pwm_en <= 1'b1;
                    end
                end
                ST_RAMP: begin
                    if (!enable_req) begin
                        r_state <= ST_STOP;
                    end else if (w_tick) begin
                        r_duty <= w_step_target;
                        if (w_step_target == r_target) begin
                            r_state     <= ST_HOLD;
                            r_at_target <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!enable_req) begin
                        r_state     <= ST_STOP;
                        r_at_target <= 1'b0;
                    end else if (r_target != r_duty) begin
                        r_state     <= ST_RAMP;
                        r_at_target <= 1'b0;
                    end
                end
                ST_STOP: begin
                    if (enable_req) begin
                        r_state <= ST_RAMP;
                    end else if (r_duty == '0) begin
                        r_state  <= ST_IDLE;
                        r_pwm_en <= 1'b0;
                    end else if (w_tick) begin
                        r_duty <= w_step_zero;
                    end
                end
                ST_FAULT: begin
                    if (clear_fault) begin
                        r_state         <= ST_IDLE;
                        r_fault_latched <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_duty   <= '0;
                    r_pwm_en <= 1'b0;
                end
            endcase
        end
    end

    assign duty          = r_duty;
    assign pwm_en        = r_pwm_en;
    assign at_target     = r_at_target;
    assign fault_latched = r_fault_latched;
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_duty_ramp_ctrl.sv
// Directed bench for duty_ramp_ctrl with a cycle-level behavioural model checked every cycle.
module tb_duty_ramp_ctrl;
    import duty_ramp_ctrl_pkg::*;

    localparam int DUTY_W   = 8;
    localparam int TICK_DIV = 4;
    localparam int STEP     = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              enable_req = 1'b0;
    logic              cmd_valid = 1'b0;
    logic [DUTY_W-1:0] cmd_duty = '0;
    logic              cmd_ready;
    logic              fault = 1'b0;
    logic              clear_fault = 1'b0;
    logic [DUTY_W-1:0] duty;
    logic              pwm_en;
    logic              at_target;
    logic              fault_latched;
    state_e            dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    duty_ramp_ctrl #(.DUTY_W(DUTY_W), .TICK_DIV(TICK_DIV), .STEP(STEP)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable_req    (enable_req),
        .cmd_valid     (cmd_valid),
        .cmd_duty      (cmd_duty),
        .cmd_ready     (cmd_ready),
        .fault         (fault),
        .clear_fault   (clear_fault),
        .duty          (duty),
        .pwm_en        (pwm_en),
        .at_target     (at_target),
        .fault_latched (fault_latched),
        .dbg_state     (dbg_state)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    state_e m_mode  = ST_IDLE;
    int     m_duty  = 0;
    int     m_tgt   = 0;
    int     m_phase = 0;
    bit     m_run, m_tk, m_acc;

    function automatic int toward(input int d, input int t);
        int df;
        df = t - d;
        if (df <= STEP && df >= -STEP) return t;
        return (df > 0) ? d + STEP : d - STEP;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode  = ST_IDLE;
            m_duty  = 0;
            m_tgt   = 0;
            m_phase = 0;
        end else begin
            m_run   = (m_mode == ST_RAMP) || (m_mode == ST_STOP);
            m_tk    = m_run && (m_phase == TICK_DIV - 1);
            m_acc   = cmd_valid && (m_mode != ST_FAULT) && !fault;
            m_phase = m_run ? (m_phase + 1) % TICK_DIV : 0;
            if (fault) begin
                m_mode = ST_FAULT;
                m_duty = 0;
            end else begin
                case (m_mode)
                    ST_IDLE:  if (enable_req && m_tgt != 0) m_mode = ST_RAMP;
                    ST_RAMP: begin
                        if (!enable_req) m_mode = ST_STOP;
                        else if (m_tk) begin
                            m_duty = toward(m_duty, m_tgt);
                            if (m_duty == m_tgt) m_mode = ST_HOLD;
                        end
                    end
                    ST_HOLD: begin
                        if (!enable_req) m_mode = ST_STOP;
                        else if (m_tgt != m_duty) m_mode = ST_RAMP;
                    end
                    ST_STOP: begin
                        if (enable_req) m_mode = ST_RAMP;
                        else if (m_duty == 0) m_mode = ST_IDLE;
                        else if (m_tk) m_duty = toward(m_duty, 0);
                    end
                    default: if (clear_fault) m_mode = ST_IDLE;
                endcase
            end
            if (m_acc) m_tgt = int'(cmd_duty);
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [DUTY_W-1:0] e_duty;
    logic              e_pwm, e_at, e_fl, e_rdy;

    always @(negedge clk) begin
        e_duty = DUTY_W'(m_duty);
        e_pwm  = (m_mode == ST_RAMP) || (m_mode == ST_HOLD) || (m_mode == ST_STOP);
        e_at   = (m_mode == ST_HOLD);
        e_fl   = (m_mode == ST_FAULT);
        e_rdy  = (m_mode != ST_FAULT) && !fault;
        n_tests++;
        if (duty !== e_duty || pwm_en !== e_pwm || at_target !== e_at ||
            fault_latched !== e_fl || cmd_ready !== e_rdy || dbg_state !== m_mode) begin
            n_fail++;
            $display("FAIL model_cmp t=%0t: duty=%0h/%0h pwm_en=%0b/%0b at_target=%0b/%0b fault_latched=%0b/%0b cmd_ready=%0b/%0b state=%0d/%0d (got/required)",
                     $time, duty, e_duty, pwm_en, e_pwm, at_target, e_at, fault_latched, e_fl,
                     cmd_ready, e_rdy, dbg_state, m_mode);
        end
    end

    // ---------------- driver / literal checks ----------------
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic send_cmd(input logic [DUTY_W-1:0] v);
        cmd_valid = 1'b1;
        cmd_duty  = v;
        cycles(1);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_state(input state_e s, input int max_cyc, input string nm);
        int k;
        k = 0;
        while (dbg_state !== s && k < max_cyc) begin
            cycles(1);
            k++;
        end
        chk(nm, 32'(dbg_state), 32'(s));
    endtask

    task automatic wait_duty(input logic [DUTY_W-1:0] v, input int max_cyc, input string nm);
        int k;
        k = 0;
        while (duty !== v && k < max_cyc) begin
            cycles(1);
            k++;
        end
        chk(nm, 32'(duty), 32'(v));
    endtask

    initial begin
        // reset values
        cycles(3);
        rst_n = 1'b1;
        #1;
        chk("rst_duty", 32'(duty), 32'h0);
        chk("rst_pwm_en", 32'(pwm_en), 32'h0);
        chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        chk("rst_cmd_ready", 32'(cmd_ready), 32'h1);

        // ramp up to 0x40
        cycles(1);
        enable_req = 1'b1;
        send_cmd(8'h40);
        cycles(4);
        chk("ramp_pre_tick", 32'(duty), 32'h00);
        cycles(1);
        chk("ramp_10", 32'(duty), 32'h10);
        chk("ramp_pwm_en", 32'(pwm_en), 32'h1);
        cycles(4);
        chk("ramp_20", 32'(duty), 32'h20);
        cycles(4);
        chk("ramp_30", 32'(duty), 32'h30);
        cycles(4);
        chk("ramp_40", 32'(duty), 32'h40);
        chk("ramp_at_target", 32'(at_target), 32'h1);

        // clamp without overshoot
        send_cmd(8'h45);
        cycles(4);
        chk("clamp_pre", 32'(duty), 32'h40);
        cycles(1);
        chk("clamp_45", 32'(duty), 32'h45);
        chk("clamp_hold", 32'(dbg_state), 32'(ST_HOLD));
        send_cmd(8'hF0);
        cycles(1);
        wait_state(ST_HOLD, 200, "to_f0_hold");
        chk("at_f0", 32'(duty), 32'hF0);
        send_cmd(8'hFF);
        cycles(4);
        chk("nowrap_pre", 32'(duty), 32'hF0);
        cycles(1);
        chk("nowrap_ff", 32'(duty), 32'hFF);

        // target zero holds at 0 with pwm_en high
        send_cmd(8'h00);
        cycles(1);
        wait_state(ST_HOLD, 200, "to_zero_hold");
        chk("zero_hold_duty", 32'(duty), 32'h0);
        chk("zero_hold_pwm_en", 32'(pwm_en), 32'h1);

        // mid-ramp reversal
        send_cmd(8'h80);
        wait_duty(8'h30, 100, "up_to_30");
        send_cmd(8'h10);
        cycles(3);
        chk("rev_20", 32'(duty), 32'h20);
        cycles(4);
        chk("rev_10", 32'(duty), 32'h10);
        chk("rev_hold", 32'(dbg_state), 32'(ST_HOLD));

        // disable ramps down to zero then idles
        send_cmd(8'h40);
        cycles(1);
        wait_state(ST_HOLD, 100, "to_40_hold");
        enable_req = 1'b0;
        cycles(5);
        chk("stop_30", 32'(duty), 32'h30);
        chk("stop_state", 32'(dbg_state), 32'(ST_STOP));
        cycles(4);
        chk("stop_20", 32'(duty), 32'h20);
        cycles(4);
        chk("stop_10", 32'(duty), 32'h10);
        cycles(4);
        chk("stop_00", 32'(duty), 32'h00);
        chk("stop_00_pwm_en", 32'(pwm_en), 32'h1);
        cycles(1);
        chk("stop_idle", 32'(dbg_state), 32'(ST_IDLE));
        chk("stop_idle_pwm_en", 32'(pwm_en), 32'h0);

        // re-enable while stopping at 0x20
        enable_req = 1'b1;
        cycles(1);
        wait_state(ST_HOLD, 100, "reramp_hold");
        enable_req = 1'b0;
        wait_duty(8'h20, 100, "down_to_20");
        enable_req = 1'b1;
        cycles(1);
        chk("reen_ramp", 32'(dbg_state), 32'(ST_RAMP));
        chk("reen_duty", 32'(duty), 32'h20);
        cycles(3);
        chk("reen_30", 32'(duty), 32'h30);
        cycles(4);
        chk("reen_40", 32'(duty), 32'h40);

        // fault at 0x30
        send_cmd(8'h20);
        cycles(1);
        wait_duty(8'h30, 50, "down_to_30");
        fault = 1'b1;
        #1;
        chk("fault_ready_comb", 32'(cmd_ready), 32'h0);
        cycles(1);
        chk("fault_duty", 32'(duty), 32'h0);
        chk("fault_pwm_en", 32'(pwm_en), 32'h0);
        chk("fault_latched", 32'(fault_latched), 32'h1);
        clear_fault = 1'b1;
        cycles(1);
        clear_fault = 1'b0;
        chk("clear_ignored", 32'(dbg_state), 32'(ST_FAULT));
        fault = 1'b0;
        enable_req = 1'b0;
        cycles(1);
        chk("fault_ready_low", 32'(cmd_ready), 32'h0);
        clear_fault = 1'b1;
        cycles(1);
        clear_fault = 1'b0;
        chk("clear_idle", 32'(dbg_state), 32'(ST_IDLE));
        chk("clear_latched", 32'(fault_latched), 32'h0);

        // command and fault in the same cycle: not accepted
        cmd_valid = 1'b1;
        cmd_duty  = 8'h99;
        fault     = 1'b1;
        cycles(1);
        cmd_valid = 1'b0;
        chk("simul_fault", 32'(dbg_state), 32'(ST_FAULT));
        fault = 1'b0;
        cycles(1);
        clear_fault = 1'b1;
        cycles(1);
        clear_fault = 1'b0;
        enable_req = 1'b1;
        cycles(1);
        chk("simul_ramp", 32'(dbg_state), 32'(ST_RAMP));
        wait_state(ST_HOLD, 100, "simul_hold");
        chk("simul_old_target", 32'(duty), 32'h20);

        // command accepted on a tick cycle: step uses the old target
        send_cmd(8'h60);
        cycles(5);
        chk("tickacc_30", 32'(duty), 32'h30);
        cycles(3);
        send_cmd(8'h00);
        chk("tickacc_40", 32'(duty), 32'h40);
        cycles(4);
        chk("tickacc_back_30", 32'(duty), 32'h30);
        chk("tickacc_ramp", 32'(dbg_state), 32'(ST_RAMP));

        // asynchronous reset mid-ramp
        rst_n = 1'b0;
        #1;
        chk("arst_duty", 32'(duty), 32'h0);
        chk("arst_pwm_en", 32'(pwm_en), 32'h0);
        chk("arst_state", 32'(dbg_state), 32'(ST_IDLE));
        cycles(2);
        rst_n = 1'b1;
        enable_req = 1'b0;
        #1;
        chk("arst_cmd_ready", 32'(cmd_ready), 32'h1);
        cycles(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
